// File: rtl/zero_detect_pipe.sv
// Pipelined masked all-zero / all-ones detector with valid/ready handshake at both ends.
// Optional statistics counter enabled by defining ZERO_DETECT_STATS_EN.
module zero_detect_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_mask,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_zero,
    output logic             out_ones,
    output logic [TAG_W-1:0] out_tag,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_zero_cnt
);

    localparam int L     = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int P     = 1 << L;
    localparam int LPS   = (STAGES > 1) ? (L + STAGES - 2) / (STAGES - 1) : L;
    localparam int NVA   = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int LASTV = (STAGES > 1) ? STAGES - 2 : 0;

    // Applying extra levels to an already-reduced vector is harmless: the padding
    // bits stay at the identity value of the operator.
    function automatic logic [P-1:0] tree_or(input logic [P-1:0] v, input int levels);
        logic [P-1:0] t;
        t = v;
        for (int l = 0; l < levels; l++) begin
            if (P > 1) begin
                for (int i = 0; i < P / 2; i++) t[i] = t[2*i] | t[2*i+1];
                for (int i = P / 2; i < P; i++) t[i] = 1'b0;
            end
        end
        return t;
    endfunction

    function automatic logic [P-1:0] tree_and(input logic [P-1:0] v, input int levels);
        logic [P-1:0] t;
        t = v;
        for (int l = 0; l < levels; l++) begin
            if (P > 1) begin
                for (int i = 0; i < P / 2; i++) t[i] = t[2*i] & t[2*i+1];
                for (int i = P / 2; i < P; i++) t[i] = 1'b1;
            end
        end
        return t;
    endfunction

    logic [STAGES-1:0] v_q, v_d, ready;
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];
    logic [P-1:0]      or_q  [NVA];
    logic [P-1:0]      or_d  [NVA];
    logic [P-1:0]      and_q [NVA];
    logic [P-1:0]      and_d [NVA];
    logic              zero_q, zero_d, ones_q, ones_d;

    logic [P-1:0]      or_in, and_in, fin_or, fin_and, red_or, red_and;
    logic              fin_v, r;

    always_comb begin
        or_in  = '0;
        and_in = '1;
        or_in[WIDTH-1:0]  = in_data & in_mask;
        and_in[WIDTH-1:0] = in_data | ~in_mask;
    end

    always_comb begin
        ready   = '0;
        r       = out_ready;
        v_d     = v_q;
        tag_d   = tag_q;
        or_d    = or_q;
        and_d   = and_q;
        zero_d  = zero_q;
        ones_d  = ones_q;
        red_or  = '0;
        red_and = '1;

        // Stage k may load when empty or when everything downstream can move.
        for (int k = STAGES - 1; k >= 0; k--) begin
            r        = ~v_q[k] | r;
            ready[k] = r;
        end

        if (ready[0]) v_d[0] = in_valid;
        if (ready[0] & in_valid) tag_d[0] = in_tag;
        for (int k = 1; k < STAGES; k++) begin
            if (ready[k]) v_d[k] = v_q[k-1];
            if (ready[k] & v_q[k-1]) tag_d[k] = tag_q[k-1];
        end

        if (STAGES > 1) begin
            if (ready[0] & in_valid) begin
                or_d[0]  = or_in;
                and_d[0] = and_in;
            end
            for (int k = 1; k < STAGES - 1; k++) begin
                if (ready[k] & v_q[k-1]) begin
                    or_d[k]  = tree_or(or_q[k-1], LPS);
                    and_d[k] = tree_and(and_q[k-1], LPS);
                end
            end
            fin_or  = or_q[LASTV];
            fin_and = and_q[LASTV];
            fin_v   = v_q[LASTV];
        end else begin
            fin_or  = or_in;
            fin_and = and_in;
            fin_v   = in_valid;
        end

        if (ready[STAGES-1] & fin_v) begin
            red_or  = tree_or(fin_or, LPS);
            red_and = tree_and(fin_and, LPS);
            zero_d  = ~red_or[0];
            ones_d  = red_and[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            zero_q <= 1'b0;
            ones_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) tag_q[k] <= '0;
            for (int k = 0; k < NVA; k++) begin
                or_q[k]  <= '0;
                and_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            zero_q <= zero_d;
            ones_q <= ones_d;
            tag_q  <= tag_d;
            or_q   <= or_d;
            and_q  <= and_d;
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = v_q[STAGES-1];
    assign out_zero  = zero_q;
    assign out_ones  = ones_q;
    assign out_tag   = tag_q[STAGES-1];

`ifdef ZERO_DETECT_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a same-cycle counting transfer; the count saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr)
            cnt_d = '0;
        else if (out_valid & out_ready & zero_q & ~&cnt_q)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign stat_zero_cnt = cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_zero_cnt   = '0;
`endif

endmodule

// File: tb/tb_zero_detect_pipe.sv
// Directed bench: a 32-bit/2-stage instance and a 5-bit/3-stage instance with a 2-bit counter.
module tb_zero_detect_pipe;

`ifdef ZERO_DETECT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: WIDTH=32, STAGES=2, CNT_W=16
    logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
    logic [31:0] a_in_data = 0, a_in_mask = 0;
    logic [3:0]  a_in_tag = 0, a_out_tag;
    logic        a_out_zero, a_out_ones, a_stat_clr = 0;
    logic [15:0] a_cnt;

    // Instance B: WIDTH=5, STAGES=3, CNT_W=2
    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
    logic [4:0]  b_in_data = 0, b_in_mask = 0;
    logic [3:0]  b_in_tag = 0, b_out_tag;
    logic        b_out_zero, b_out_ones, b_stat_clr = 0;
    logic [1:0]  b_cnt;

    zero_detect_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_mask(a_in_mask), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_zero(a_out_zero),
        .out_ones(a_out_ones), .out_tag(a_out_tag),
        .stat_clr(a_stat_clr), .stat_zero_cnt(a_cnt)
    );

    zero_detect_pipe #(.WIDTH(5), .STAGES(3), .TAG_W(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_mask(b_in_mask), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_zero(b_out_zero),
        .out_ones(b_out_ones), .out_tag(b_out_tag),
        .stat_clr(b_stat_clr), .stat_zero_cnt(b_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    // One operand through A with out_ready=1; optional stat_clr during its delivery.
    task automatic a_op(input logic [31:0] d, input logic [31:0] m, input logic [3:0] t,
                        input logic ez, input logic eo, input logic clr);
        int lat;
        @(negedge clk);
        a_in_valid = 1; a_in_data = d; a_in_mask = m; a_in_tag = t;
        for (int i = 0; i < 20 && !a_in_ready; i++) @(negedge clk);
        check("a_in_ready", a_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 0;
        lat = 1;
        while (!a_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("a_latency", lat, 2);
        check("a_zero", a_out_zero, ez);
        check("a_ones", a_out_ones, eo);
        check("a_tag", a_out_tag, t);
        a_stat_clr = clr;
        @(negedge clk);
        a_stat_clr = 0;
    endtask

    task automatic b_op(input logic [4:0] d, input logic [4:0] m, input logic [3:0] t,
                        input logic ez, input logic eo);
        int lat;
        @(negedge clk);
        b_in_valid = 1; b_in_data = d; b_in_mask = m; b_in_tag = t;
        for (int i = 0; i < 20 && !b_in_ready; i++) @(negedge clk);
        check("b_in_ready", b_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 0;
        lat = 1;
        while (!b_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b_latency", lat, 3);
        check("b_zero", b_out_zero, ez);
        check("b_ones", b_out_ones, eo);
        check("b_tag", b_out_tag, t);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_zero", a_out_zero, 0);
        check("rst_a_ones", a_out_ones, 0);
        check("rst_a_tag", a_out_tag, 0);
        check("rst_a_cnt", a_cnt, 0);
        check("rst_b_valid", b_out_valid, 0);
        rst = 0;
        @(negedge clk);
        check("a_ready_after_rst", a_in_ready, 1);

        // Basic flag patterns
        a_op(32'h0000_0000, 32'hFFFF_FFFF, 4'd3, 1, 0, 0);
        a_op(32'hFFFF_0000, 32'hFFFF_0000, 4'd4, 0, 1, 0);
        a_op(32'hFFFF_0000, 32'h0000_FFFF, 4'd5, 1, 0, 0);
        a_op(32'hFFFF_0000, 32'h0000_0000, 4'd6, 1, 1, 0);
        a_op(32'h8000_0001, 32'hFFFF_FFFF, 4'd7, 0, 0, 0);

        // Backpressure: fill with out_ready=0, check hold, then drain in order
        a_out_ready = 0;
        @(negedge clk);
        a_in_valid = 1; a_in_data = 32'h0; a_in_mask = 32'hFFFF_FFFF; a_in_tag = 4'd1;
        @(posedge clk);
        @(negedge clk);
        check("stall_ready_1", a_in_ready, 1);
        a_in_data = 32'hFFFF_FFFF; a_in_tag = 4'd2;
        @(posedge clk);
        @(negedge clk);
        a_in_data = 32'h0000_0100; a_in_mask = 32'h0000_0100; a_in_tag = 4'd3;
        check("stall_ready_full", a_in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold_valid", a_out_valid, 1);
            check("stall_hold_tag", a_out_tag, 1);
            check("stall_hold_zero", a_out_zero, 1);
            check("stall_hold_ready", a_in_ready, 0);
        end
        a_out_ready = 1;
        #1;
        check("stall_ready_follow", a_in_ready, 1);
        check("drain_tag1", a_out_tag, 1);
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 0;
        check("drain_valid2", a_out_valid, 1);
        check("drain_tag2", a_out_tag, 2);
        check("drain_ones2", a_out_ones, 1);
        @(negedge clk);
        check("drain_valid3", a_out_valid, 1);
        check("drain_tag3", a_out_tag, 3);
        check("drain_ones3", a_out_ones, 1);
        check("drain_zero3", a_out_zero, 0);
        @(negedge clk);
        check("drain_empty", a_out_valid, 0);

        // Non-power-of-two width, three stages
        b_op(5'h1F, 5'h1F, 4'd1, 0, 1);
        b_op(5'h10, 5'h0F, 4'd2, 1, 0);
        b_op(5'h0F, 5'h1F, 4'd3, 0, 0);
        check("b_cnt_1", b_cnt, STATS ? 2'd1 : 2'd0);
        b_op(5'h00, 5'h1F, 4'd4, 1, 0);
        b_op(5'h10, 5'h01, 4'd5, 1, 0);
        check("b_cnt_3", b_cnt, STATS ? 2'd3 : 2'd0);
        for (int i = 0; i < 3; i++) b_op(5'h00, 5'h00, 4'(6 + i), 1, 1);
        check("b_cnt_sat", b_cnt, STATS ? 2'd3 : 2'd0);

        // Statistics on A
        @(negedge clk);
        a_stat_clr = 1;
        @(negedge clk);
        a_stat_clr = 0;
        check("a_cnt_clr", a_cnt, 0);
        a_op(32'h0000_0000, 32'hFFFF_FFFF, 4'd1, 1, 0, 0);
        a_op(32'h0000_0F00, 32'h0000_00FF, 4'd2, 1, 0, 0);
        a_op(32'h0000_0001, 32'h0000_0001, 4'd3, 0, 1, 0);
        a_op(32'h1234_5678, 32'h0000_0000, 4'd4, 1, 1, 0);
        a_op(32'h0000_0003, 32'h0000_000F, 4'd5, 0, 0, 0);
        a_op(32'hF000_0000, 32'h0FFF_FFFF, 4'd6, 1, 0, 0);
        check("a_cnt_4", a_cnt, STATS ? 16'd4 : 16'd0);
        a_op(32'h0000_0000, 32'hFFFF_FFFF, 4'd7, 1, 0, 1);
        check("a_cnt_clr_xfer", a_cnt, 0);

        // Reset with two operands in flight
        a_out_ready = 0;
        @(negedge clk);
        a_in_valid = 1; a_in_data = 32'h0; a_in_mask = 32'hFFFF_FFFF; a_in_tag = 4'd8;
        @(posedge clk);
        @(negedge clk);
        a_in_tag = 4'd9;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        a_out_ready = 1;
        check("rst2_valid", a_out_valid, 0);
        check("rst2_tag", a_out_tag, 0);
        check("rst2_zero", a_out_zero, 0);
        check("rst2_ready", a_in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst2_no_stale", a_out_valid, 0);
        end
        a_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 0, 1, 0);
        @(negedge clk);
        check("rst2_after_empty", a_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
